// File: rtl/and_out_qualifier_pkg.sv
// and_out_qualifier_pkg: debounce FSM state encoding and default parameter values
// shared by the qualifier and its testbench.
package and_out_qualifier_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_PEND = 2'd1,
        HIGH      = 2'd2,
        FALL_PEND = 2'd3
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit.
// Ports: clock, reset_n (async active-low), d (async input), q (synchronized output).
module sync2 (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end

endmodule

// File: rtl/and_out_qualifier.sv
// and_out_qualifier: synchronizes and debounces an AND-tree output, emits edge pulses,
// and counts accepted rises with a read-and-clear port.
// Ports: clock, reset_n (async active-low); sig_in (async level);
//        filt_out / rise_pulse / fall_pulse (debounced level and edge pulses);
//        rd_req -> rd_valid strobe with rd_data (rise count) and rd_ovf (saturation seen).
module and_out_qualifier
    import and_out_qualifier_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic             filt_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_ovf
);

    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

    logic             s2;
    state_t           state;
    logic [7:0]       dcnt;
    logic [CNT_W-1:0] count;
    logic             ovf;

    sync2 u_sync2 (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (sig_in),
        .q      (s2)
    );

    // dcnt counts consecutive samples at the new level; the sample that enters a
    // pending state counts as the first one.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state      <= LOW;
            dcnt       <= 8'd0;
            filt_out   <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            case (state)
                LOW:
                    if (s2) begin
                        state <= RISE_PEND;
                        dcnt  <= 8'd1;
                    end
                RISE_PEND:
                    if (!s2) begin
                        state <= LOW;
                        dcnt  <= 8'd0;
                    end else if (dcnt == LAST) begin
                        state      <= HIGH;
                        dcnt       <= 8'd0;
                        filt_out   <= 1'b1;
                        rise_pulse <= 1'b1;
                    end else
                        dcnt <= dcnt + 8'd1;
                HIGH:
                    if (!s2) begin
                        state <= FALL_PEND;
                        dcnt  <= 8'd1;
                    end
                FALL_PEND:
                    if (s2) begin
                        state <= HIGH;
                        dcnt  <= 8'd0;
                    end else if (dcnt == LAST) begin
                        state      <= LOW;
                        dcnt       <= 8'd0;
                        filt_out   <= 1'b0;
                        fall_pulse <= 1'b1;
                    end else
                        dcnt <= dcnt + 8'd1;
                default: state <= LOW;
            endcase
        end

    // A read captures the pre-edge count and restarts it from the rise landing on
    // that same edge, so no event slips between capture and clear.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            count    <= '0;
            ovf      <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ovf   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= count;
                rd_ovf  <= ovf;
                count   <= rise_pulse ? CNT_W'(1) : '0;
                ovf     <= 1'b0;
            end else if (rise_pulse) begin
                if (&count)
                    ovf <= 1'b1;
                else
                    count <= count + CNT_W'(1);
            end
        end

endmodule

// File: tb/tb_and_out_qualifier.sv
// tb_and_out_qualifier: directed self-checking bench for and_out_qualifier.
module tb_and_out_qualifier;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       sig_in;
    logic       filt_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ovf;

    int checks = 0;
    int errors = 0;

    and_out_qualifier dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .sig_in    (sig_in),
        .filt_out  (filt_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .rd_req    (rd_req),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ovf    (rd_ovf)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_rise();
        sig_in = 1'b1;
        step(8);
        sig_in = 1'b0;
        step(8);
    endtask

    task automatic read_check(input string tag, input logic [7:0] exp_data, input logic exp_ovf);
        rd_req = 1'b1;
        step(1);
        rd_req = 1'b0;
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, exp_data);
        check({tag, "_ovf"}, rd_ovf, exp_ovf);
        step(1);
        check({tag, "_valid_drop"}, rd_valid, 0);
        check({tag, "_data_hold"}, rd_data, exp_data);
    endtask

    initial begin
        reset_n = 1'b0;
        sig_in  = 1'b0;
        rd_req  = 1'b0;
        step(2);
        check("rst_filt", filt_out, 0);
        check("rst_rise", rise_pulse, 0);
        check("rst_fall", fall_pulse, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_ovf", rd_ovf, 0);
        reset_n = 1'b1;
        step(2);

        // Scenario 1: accepted rise after edge 5, one-cycle pulse, count 1
        sig_in = 1'b1;
        step(5);
        check("s1_filt_e4", filt_out, 0);
        check("s1_rise_e4", rise_pulse, 0);
        step(1);
        check("s1_filt_e5", filt_out, 1);
        check("s1_rise_e5", rise_pulse, 1);
        step(1);
        check("s1_rise_e6", rise_pulse, 0);
        check("s1_filt_e6", filt_out, 1);
        read_check("s1_rd", 8'd1, 1'b0);
        sig_in = 1'b0;
        step(5);
        check("s1_fall_e4", fall_pulse, 0);
        check("s1_filtf_e4", filt_out, 1);
        step(1);
        check("s1_fall_e5", fall_pulse, 1);
        check("s1_filtf_e5", filt_out, 0);
        step(1);
        check("s1_fall_e6", fall_pulse, 0);

        // Scenario 2: 3-sample glitch is rejected
        sig_in = 1'b1;
        step(3);
        sig_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("s2_rise", rise_pulse, 0);
            check("s2_fall", fall_pulse, 0);
            check("s2_filt", filt_out, 0);
            step(1);
        end
        read_check("s2_rd", 8'd0, 1'b0);

        // Scenario 3: five rises, read, then cleared
        repeat (5) pulse_rise();
        read_check("s3_rd", 8'd5, 1'b0);
        read_check("s3_rd0", 8'd0, 1'b0);

        // Scenario 4: saturation with back-to-back reads
        repeat (257) pulse_rise();
        rd_req = 1'b1;
        step(1);
        check("s4_valid1", rd_valid, 1);
        check("s4_data1", rd_data, 8'd255);
        check("s4_ovf1", rd_ovf, 1);
        step(1);
        rd_req = 1'b0;
        check("s4_valid2", rd_valid, 1);
        check("s4_data2", rd_data, 0);
        check("s4_ovf2", rd_ovf, 0);
        step(1);
        check("s4_valid3", rd_valid, 0);

        // Scenario 5: read on the same edge as a rise pulse
        repeat (3) pulse_rise();
        sig_in = 1'b1;
        step(6);
        check("s5_rise", rise_pulse, 1);
        rd_req = 1'b1;
        step(1);
        rd_req = 1'b0;
        check("s5_valid", rd_valid, 1);
        check("s5_data", rd_data, 8'd3);
        sig_in = 1'b0;
        step(8);
        read_check("s5_rd1", 8'd1, 1'b0);

        // Scenario 6: reset during RISE_PEND with dcnt=2
        sig_in = 1'b1;
        step(4);
        reset_n = 1'b0;
        #1;
        check("s6_filt", filt_out, 0);
        check("s6_rise", rise_pulse, 0);
        check("s6_fall", fall_pulse, 0);
        check("s6_valid", rd_valid, 0);
        check("s6_data", rd_data, 0);
        check("s6_ovf", rd_ovf, 0);
        step(1);
        reset_n = 1'b1;
        step(5);
        check("s6_rise_e4", rise_pulse, 0);
        check("s6_filt_e4", filt_out, 0);
        step(1);
        check("s6_rise_e5", rise_pulse, 1);
        check("s6_filt_e5", filt_out, 1);
        step(1);
        read_check("s6_rd", 8'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
